instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch front end: the initiator side of the instruction-memory read interface.
- Holds the PC and drives a byte address plus a read enable into the combinational-read instruction memory.
- Captures each returned word together with its PC into a 2-entry fetch queue, which it presents to decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from execute, which flush the queue.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 10, byte-address width of the instruction memory. Word index is addr[ADDR_WIDTH-1:2].
- RESET_PC, 0, PC value loaded on reset. Must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_addr  output  ADDR_WIDTH  byte address to instruction memory; always equals the PC register.
- mem_re  output  1  read enable to instruction memory (combinational).
- mem_instr  input  INSTR_WIDTH  word returned by memory in the same cycle as mem_addr/mem_re.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] are ignored.
- id_valid  output  1  queue head valid for decode.
- id_ready  input  1  decode accepts the head this cycle.
- id_instr  output  INSTR_WIDTH  instruction at queue head; 0 when id_valid=0.
- id_pc  output  ADDR_WIDTH  PC of queue head; 0 when id_valid=0.

Behaviour:
- State:
  - pc register (ADDR_WIDTH bits).
  - 2-entry queue of {pc, instr} with head pointer, tail pointer and count (0..2).
- Reset: on a clk edge with rst=1:
  - pc <= RESET_PC and count <= 0.
  - Consequently id_valid=0, id_instr=0, id_pc=0.
  - mem_re=0 while rst=1.
  - rst has priority over every other input, including a mid-flight redirect or pop.
- Derived combinational signals:
  - pop = id_valid & id_ready.
  - can_push = (count < 2) | pop.
  - mem_re = ~rst & ~redirect_valid & can_push.
  - mem_addr = pc.
- Fetch: on an edge with mem_re=1:
  - Push {pc, mem_instr} at the tail.
  - pc <= pc + 4, wrapping modulo 2^ADDR_WIDTH (carry discarded).
  - If mem_re=0, pc holds.
- Decode side:
  - id_valid = (count != 0).
  - id_instr and id_pc come from the head entry, or 0 when the queue is empty.
  - The head is held stable until popped.
  - On pop, the head advances.
- Latency:
  - A word fetched in cycle N is visible on id_* in cycle N+1.
  - There is no bypass from memory to decode when the queue is empty.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, including at count=2 (full, streaming) and count=1.
- Full: with count=2 and no pop, mem_re=0 and pc holds. No word is lost or duplicated.
- Empty: with count=0, id_ready is ignored and no pop occurs.
- Redirect (redirect_valid=1, rst=0):
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - Queue flushed (count <= 0).
  - No push that cycle (mem_re=0).
  - Any pop that cycle is discarded. Decode must treat the flushed head as squashed, and the flush wins over pop.
  - Next cycle: id_valid=0 and fetch resumes at the new pc.
  - Back-to-back redirects: the last one wins, and mem_re stays 0 while redirect_valid=1.
- Wrap-around:
  - Queue pointers are 1 bit and wrap mod 2.
  - PC wraps from 2^ADDR_WIDTH-4 to 0.

Test Plan:
- Reset, then id_ready=1 constantly; memory returns word = 0x00100013 + addr:
  - mem_addr sequence 0x000, 0x004, 0x008 …
  - id_valid rises 1 cycle after reset release.
  - id_pc 0x000, 0x004 … one per cycle, and id_instr matches its address.
- id_ready=0 for 5 cycles after reset:
  - count reaches 2 after 2 fetches, mem_re drops, pc holds at 0x008.
  - Raising id_ready delivers pc 0x000, 0x004, 0x008 in order with no gaps after the first.
- Full queue with id_ready=1 on the same cycle:
  - Push and pop occur together, count stays 2 and mem_re=1.
  - id_pc increments by 4 each cycle.
- redirect_valid=1, redirect_pc=0x043 while count=2:
  - Next cycle id_valid=0 and mem_addr=0x040.
  - The following cycle id_pc=0x040; pre-redirect entries never appear.
- PC wrap with ADDR_WIDTH=10:
  - Redirect to 0x3F8, then free-run.
  - mem_addr sequence 0x3F8, 0x3FC, 0x000.
  - id_pc sequence matches.
- rst asserted for 1 cycle while count=2 and redirect_valid=1:
  - Next cycle count=0, pc=RESET_PC, and id_instr=0, id_pc=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: holds the PC, reads a combinational instruction
// memory and queues {pc, instr} pairs in a 2-entry queue for decode.
// Latency: a word fetched in cycle N appears on id_* in cycle N+1 (no bypass).
// Backpressure: when the queue is full and decode does not pop, mem_re drops and the PC holds.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_addr, mem_re         byte address / read enable to instruction memory
//   mem_instr                word returned by memory in the same cycle
//   redirect_valid/_pc       PC change from execute; flushes the queue
//   id_valid, id_ready       valid/ready handshake to decode
//   id_instr, id_pc          queue head contents (0 when the queue is empty)
module instr_fetch #(
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    ADDR_WIDTH  = 10,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic                   mem_re,
   input  logic [INSTR_WIDTH-1:0] mem_instr,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [INSTR_WIDTH-1:0] id_instr,
   output logic [ADDR_WIDTH-1:0]  id_pc
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   logic [ADDR_WIDTH-1:0]  pc;
   logic [ADDR_WIDTH-1:0]  q_pc    [2];
   logic [INSTR_WIDTH-1:0] q_instr [2];
   logic                   head;
   logic                   tail;
   logic [1:0]             count;

   logic pop;
   logic can_push;

   assign id_valid = (count != 2'd0);
   assign pop      = id_valid & id_ready;
   // A pop frees a slot in the same cycle, so a full queue can still stream.
   assign can_push = (count < 2'd2) | pop;
   assign mem_re   = ~rst & ~redirect_valid & can_push;
   assign mem_addr = pc;

   assign id_instr = id_valid ? q_instr[head] : '0;
   assign id_pc    = id_valid ? q_pc[head]    : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else if (redirect_valid) begin
         // Flush wins over any pop this cycle; the popped head is squashed.
         pc    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (mem_re) begin
            pc   <= pc + PC_STEP;
            tail <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({mem_re, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Queue storage needs no reset: entries are only read while count covers them.
   always_ff @(posedge clk) begin
      if (mem_re) begin
         q_pc[tail]    <= pc;
         q_instr[tail] <= mem_instr;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  mem_addr;
   logic        mem_re;
   logic [31:0] mem_instr;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [9:0]  id_pc;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] BASE = 32'h00100013;

   instr_fetch #(.INSTR_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(10'h000)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_addr       (mem_addr),
      .mem_re         (mem_re),
      .mem_instr      (mem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   always #5 clk = ~clk;

   // Memory model: word = BASE + byte address.
   assign mem_instr = BASE + {22'd0, mem_addr};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked 1 time unit later.
   task automatic drive(input logic r, input logic rv, input logic [9:0] rpc, input logic rdy);
      @(negedge clk);
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
      #1;
   endtask

   task automatic expect_head(input string tag, input logic [9:0] pc);
      check({tag, "_vld"}, {31'd0, id_valid}, 32'd1);
      check({tag, "_pc"}, {22'd0, id_pc}, {22'd0, pc});
      check({tag, "_instr"}, id_instr, BASE + {22'd0, pc});
   endtask

   task automatic expect_empty(input string tag);
      check({tag, "_vld"}, {31'd0, id_valid}, 32'd0);
      check({tag, "_pc"}, {22'd0, id_pc}, 32'd0);
      check({tag, "_instr"}, id_instr, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

      // Reset with decode always ready: one word per cycle.
      drive(1'b1, 1'b0, 10'h000, 1'b1);
      check("rst_mem_re", {31'd0, mem_re}, 32'd0);
      drive(1'b1, 1'b0, 10'h000, 1'b1);
      check("rst_mem_re2", {31'd0, mem_re}, 32'd0);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_empty("rel");
      check("rel_addr", {22'd0, mem_addr}, 32'h000);
      check("rel_re", {31'd0, mem_re}, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 1'b0, 10'h000, 1'b1);
         expect_head("run", 10'(4 * (k - 1)));
         check("run_addr", {22'd0, mem_addr}, 32'(4 * k));
         check("run_re", {31'd0, mem_re}, 32'd1);
      end

      // Stall decode for 5 cycles: queue fills at 2, PC holds at 0x008.
      drive(1'b1, 1'b0, 10'h000, 1'b0);
      drive(1'b0, 1'b0, 10'h000, 1'b0);
      check("st0_re", {31'd0, mem_re}, 32'd1);
      drive(1'b0, 1'b0, 10'h000, 1'b0);
      expect_head("st1", 10'h000);
      check("st1_addr", {22'd0, mem_addr}, 32'h004);
      for (int k = 2; k <= 4; k++) begin
         drive(1'b0, 1'b0, 10'h000, 1'b0);
         check("full_re", {31'd0, mem_re}, 32'd0);
         check("full_addr", {22'd0, mem_addr}, 32'h008);
         expect_head("full", 10'h000);
      end
      // Release: full queue streams with push and pop together.
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_head("str0", 10'h000);
      check("str0_re", {31'd0, mem_re}, 32'd1);
      check("str0_addr", {22'd0, mem_addr}, 32'h008);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_head("str1", 10'h004);
      check("str1_re", {31'd0, mem_re}, 32'd1);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_head("str2", 10'h008);
      check("str2_addr", {22'd0, mem_addr}, 32'h010);

      // Redirect to 0x043 while full and popping: flush wins.
      drive(1'b0, 1'b1, 10'h043, 1'b1);
      check("redir_re", {31'd0, mem_re}, 32'd0);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_empty("redir1");
      check("redir1_addr", {22'd0, mem_addr}, 32'h040);
      check("redir1_re", {31'd0, mem_re}, 32'd1);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_head("redir2", 10'h040);
      check("redir2_addr", {22'd0, mem_addr}, 32'h044);

      // Back-to-back redirects, last wins, then PC wrap.
      drive(1'b0, 1'b1, 10'h100, 1'b1);
      check("b2b0_re", {31'd0, mem_re}, 32'd0);
      drive(1'b0, 1'b1, 10'h3F9, 1'b1);
      check("b2b1_re", {31'd0, mem_re}, 32'd0);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_empty("wrap0");
      check("wrap0_addr", {22'd0, mem_addr}, 32'h3F8);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_head("wrap1", 10'h3F8);
      check("wrap1_addr", {22'd0, mem_addr}, 32'h3FC);
      drive(1'b0, 1'b0, 10'h000, 1'b1);
      expect_head("wrap2", 10'h3FC);
      check("wrap2_addr", {22'd0, mem_addr}, 32'h000);
      // Stop popping so the queue refills to 2.
      drive(1'b0, 1'b0, 10'h000, 1'b0);
      expect_head("wrap3", 10'h000);
      check("wrap3_addr", {22'd0, mem_addr}, 32'h004);

      // Full queue: rst and redirect together, rst has priority.
      drive(1'b1, 1'b1, 10'h200, 1'b1);
      check("rr_re", {31'd0, mem_re}, 32'd0);
      drive(1'b0, 1'b0, 10'h000, 1'b0);
      expect_empty("rr");
      check("rr_addr", {22'd0, mem_addr}, 32'h000);
      check("rr_re1", {31'd0, mem_re}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
